result_uart_tx: RTL

Reader side of the lap-result memory. On request, it walks the stored lap results from address 0 to the last one and reads each 24-bit BCD entry. Each entry is formatted as an ASCII text line and sent out on a UART TX pin (8N1). It sits beside the result memory in the stopwatch top and shares its read port while the display is not in result-view mode.

---
 rtl/result_uart_tx.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/result_uart_tx.sv
// Walks the stored lap results and sends each one as a 12-character ASCII line
// ("i dd:dd.dd\r\n") on an 8N1 UART pin.
module result_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_W       = 4,
  parameter int DATA_W       = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dump,
  input  logic [ADDR_W:0]   n_results,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_STOP = BAUD_W'(CLKS_PER_BIT - 2);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_LATCH = 3'd2,
    S_LOAD  = 3'd3,
    S_SHIFT = 3'd4,
    S_FIN   = 3'd5
  } state_t;

  state_t              state, state_nxt;
  logic [BAUD_W-1:0]   baud_cnt;
  logic [3:0]          bit_cnt;
  logic [3:0]          char_idx;
  logic [ADDR_W-1:0]   idx;
  logic [ADDR_W:0]     count_q;
  logic [DATA_W-1:0]   line_q;
  logic [9:0]          shreg;
  logic [7:0]          char_cur;
  logic                bit_end;
  logic                frame_end;
  logic                last_char;
  logic                more_recs;

  function automatic logic [7:0] hex_ascii(input logic [3:0] v);
    return (v < 4'd10) ? (8'h30 + {4'h0, v}) : (8'h37 + {4'h0, v});
  endfunction

  assign rd_addr   = idx;
  assign bit_end   = (baud_cnt == BAUD_LAST);
  // The stop bit ends one clock early in SHIFT; the following LOAD (or FIN/ADDR)
  // cycle idles high and completes it, so characters stay back to back.
  assign frame_end = (bit_cnt == 4'd9) && (baud_cnt == BAUD_STOP);
  assign last_char = (char_idx == 4'd11);
  assign more_recs = ((ADDR_W+1)'(idx) + (ADDR_W+1)'(1)) < count_q;

  always_comb begin
    char_cur = 8'h0A;
    case (char_idx)
      4'd0:    char_cur = hex_ascii(4'(idx));
      4'd1:    char_cur = 8'h20;
      4'd2:    char_cur = hex_ascii(line_q[23:20]);
      4'd3:    char_cur = hex_ascii(line_q[19:16]);
      4'd4:    char_cur = 8'h3A;
      4'd5:    char_cur = hex_ascii(line_q[15:12]);
      4'd6:    char_cur = hex_ascii(line_q[11:8]);
      4'd7:    char_cur = 8'h2E;
      4'd8:    char_cur = hex_ascii(line_q[7:4]);
      4'd9:    char_cur = hex_ascii(line_q[3:0]);
      4'd10:   char_cur = 8'h0D;
      default: char_cur = 8'h0A;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (dump) state_nxt = (n_results == '0) ? S_FIN : S_ADDR;
      S_ADDR:  state_nxt = S_LATCH;
      S_LATCH: state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_SHIFT;
      S_SHIFT: begin
        if (frame_end) begin
          if (!last_char)     state_nxt = S_LOAD;
          else if (more_recs) state_nxt = S_ADDR;
          else                state_nxt = S_FIN;
        end
      end
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    tx   = 1'b1;
    busy = 1'b0;
    done = 1'b0;
    case (state)
      S_ADDR, S_LATCH, S_LOAD: busy = 1'b1;
      S_SHIFT: begin
        busy = 1'b1;
        tx   = shreg[0];
      end
      S_FIN:   done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      char_idx <= '0;
      idx      <= '0;
      count_q  <= '0;
      line_q   <= '0;
      shreg    <= '1;
    end else begin
      case (state)
        S_IDLE: begin
          if (dump && (n_results != '0)) begin
            count_q <= n_results;
            idx     <= '0;
          end
        end
        S_LATCH: begin
          line_q   <= rd_data;
          char_idx <= '0;
        end
        S_LOAD: begin
          shreg    <= {1'b1, char_cur, 1'b0};
          bit_cnt  <= '0;
          baud_cnt <= '0;
        end
        S_SHIFT: begin
          if (frame_end) begin
            if (!last_char)     char_idx <= char_idx + 4'd1;
            else if (more_recs) idx      <= idx + 1'b1;
          end else if (bit_end) begin
            baud_cnt <= '0;
            bit_cnt  <= bit_cnt + 4'd1;
            shreg    <= {1'b1, shreg[9:1]};
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
